rtcl_hs_rx: RTL and testbench

- Receive-side counterpart of the HS transmit packer on the PYTHON300 + Spartan-7 MIPI link.
- Takes lane-parallel words from the D-PHY receiver (DPHY_LANES*8 bits per beat, LSB-first, with a start-of-burst flag and an end-of-burst flag).
- Re-packs them into CHANNELS*RAW_BITS pixel words with first/last markers for the downstream sensor-data path.
- Discards data outside a packet and reports framing errors.

---
 rtl/rtcl_hs_rx.sv | 178 +++++++++++++++++
 tb/tb_rtcl_hs_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rtcl_hs_rx.sv
// ---------------------------------------------------------------------------
// rtcl_hs_rx : HS receive re-packer for the PYTHON300 / Spartan-7 MIPI link.
//
// Collects lane-parallel D-PHY beats (S_BITS = DPHY_LANES*8, LSB-first) into
// an accumulator and emits CHANNELS*RAW_BITS pixel words with first/last
// markers. Beats outside a packet are dropped, and framing errors are flagged.
//
// Ports
//   reset      in   async active-high reset
//   clk        in   clock
//   cke        in   clock enable, all state holds when low
//   s_first    in   first beat of a burst
//   s_last     in   last beat of a burst
//   s_data     in   lane data [S_BITS-1:0]
//   s_valid    in   input valid
//   s_ready    out  input ready
//   m_first    out  first pixel word of a packet
//   m_last     out  last pixel word of a packet
//   m_data     out  pixel word [M_BITS-1:0], channel 0 in the LSBs
//   m_valid    out  output valid
//   m_ready    in   output ready
//   err_first  out  pulse: s_first accepted while a packet was open
//   err_orphan out  pulse: beat accepted outside a packet
// ---------------------------------------------------------------------------
module rtcl_hs_rx #(
  parameter int CHANNELS   = 4,
  parameter int RAW_BITS   = 10,
  parameter int DPHY_LANES = 2,
  parameter     DEVICE     = "RTL",
  parameter     SIMULATION = "false",
  parameter     DEBUG      = "false"
) (
  input  logic                           reset,
  input  logic                           clk,
  input  logic                           cke,
  input  logic                           s_first,
  input  logic                           s_last,
  input  logic [DPHY_LANES*8-1:0]        s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic                           m_first,
  output logic                           m_last,
  output logic [CHANNELS*RAW_BITS-1:0]   m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           err_first,
  output logic                           err_orphan
);

  localparam int S_BITS = DPHY_LANES * 8;
  localparam int M_BITS = CHANNELS * RAW_BITS;
  localparam int ACC_W  = M_BITS + S_BITS;
  localparam int CNT_W  = $clog2(ACC_W);

  localparam logic [CNT_W-1:0] M_CNT = CNT_W'(M_BITS);
  localparam logic [CNT_W-1:0] S_CNT = CNT_W'(S_BITS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  generate
    if (M_BITS < S_BITS) begin : g_bad_cfg
      $error("rtcl_hs_rx: M_BITS < S_BITS (DEVICE=%s SIMULATION=%s DEBUG=%s)",
             DEVICE, SIMULATION, DEBUG);
    end
  endgenerate

  logic [1:0]        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  acc_count_q, acc_count_d;
  logic              pend_first_q, pend_first_d;
  logic              m_valid_q, m_valid_d;
  logic              m_first_q, m_first_d;
  logic              m_last_q, m_last_d;
  logic [M_BITS-1:0] m_data_q, m_data_d;
  logic              err_first_q, err_first_d;
  logic              err_orphan_q, err_orphan_d;

  logic              accept;
  logic              load;
  logic              final_word;
  logic [ACC_W-1:0]  beat_ext;

  assign s_ready    = cke && (acc_count_q < M_CNT) && (state_q != FLUSH);
  assign accept     = s_valid && s_ready;
  // In FLUSH the word holding the remaining bits (full or padded) is the last.
  assign final_word = (state_q == FLUSH) && (acc_count_q <= M_CNT);
  assign load       = cke && (!m_valid_q || m_ready) &&
                      ((acc_count_q >= M_CNT) ||
                       ((state_q == FLUSH) && (acc_count_q != '0)));
  assign beat_ext   = {{M_BITS{1'b0}}, s_data};

  // Invariant: accumulator bits at and above acc_count are zero, so a beat
  // can be OR-ed in and a residual word comes out zero-padded.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    acc_count_d  = acc_count_q;
    pend_first_d = pend_first_q;
    m_valid_d    = m_valid_q;
    m_first_d    = m_first_q;
    m_last_d     = m_last_q;
    m_data_d     = m_data_q;
    err_first_d  = err_first_q;
    err_orphan_d = err_orphan_q;

    if (cke) begin
      err_first_d  = 1'b0;
      err_orphan_d = 1'b0;
      if (m_ready) m_valid_d = 1'b0;

      if (load) begin
        m_data_d     = acc_q[M_BITS-1:0];
        m_valid_d    = 1'b1;
        m_first_d    = pend_first_q;
        m_last_d     = final_word;
        pend_first_d = 1'b0;
        acc_d        = acc_q >> M_BITS;
        acc_count_d  = (acc_count_q > M_CNT) ? acc_count_q - M_CNT : '0;
        if (final_word) state_d = IDLE;
      end else if ((state_q == FLUSH) && (acc_count_q == '0)) begin
        state_d = IDLE;
      end

      // Append lands after any shift above (at the post-shift fill level).
      if (accept) begin
        if (s_first) begin
          err_first_d  = (state_q == BUSY);
          acc_d        = beat_ext;
          acc_count_d  = S_CNT;
          pend_first_d = 1'b1;
          state_d      = s_last ? FLUSH : BUSY;
        end else if (state_q == BUSY) begin
          acc_d       = acc_d | (beat_ext << acc_count_d);
          acc_count_d = acc_count_d + S_CNT;
          if (s_last) state_d = FLUSH;
        end else begin
          err_orphan_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      acc_count_q  <= '0;
      pend_first_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_first_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_data_q     <= '0;
      err_first_q  <= 1'b0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      acc_count_q  <= acc_count_d;
      pend_first_q <= pend_first_d;
      m_valid_q    <= m_valid_d;
      m_first_q    <= m_first_d;
      m_last_q     <= m_last_d;
      m_data_q     <= m_data_d;
      err_first_q  <= err_first_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_first    = m_first_q;
  assign m_last     = m_last_q;
  assign m_data     = m_data_q;
  assign err_first  = err_first_q;
  assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_rtcl_hs_rx.sv
// ---------------------------------------------------------------------------
// tb_rtcl_hs_rx : directed self-checking bench for rtcl_hs_rx (default
// parameters: 16-bit beats, 40-bit pixel words).
// ---------------------------------------------------------------------------
module tb_rtcl_hs_rx;

  logic        reset, clk, cke;
  logic        s_first, s_last, s_valid, s_ready;
  logic [15:0] s_data;
  logic        m_first, m_last, m_valid, m_ready;
  logic [39:0] m_data;
  logic        err_first, err_orphan;

  int total = 0;
  int bad   = 0;

  // words observed at the output handshake
  logic [39:0] w_data  [8];
  logic        w_first [8];
  logic        w_last  [8];
  int          nw = 0;
  int          n_orphan = 0;
  int          n_errfirst = 0;
  int          hold_viol = 0;
  logic        prev_stall = 1'b0;
  logic [39:0] prev_data = '0;
  logic        toggle_en = 1'b0;

  rtcl_hs_rx dut (
    .reset(reset), .clk(clk), .cke(cke),
    .s_first(s_first), .s_last(s_last), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready),
    .m_first(m_first), .m_last(m_last), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready),
    .err_first(err_first), .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_valid && m_ready) begin
        if (nw < 8) begin
          w_data[nw]  = m_data;
          w_first[nw] = m_first;
          w_last[nw]  = m_last;
        end
        nw++;
      end
      if (err_orphan) n_orphan++;
      if (err_first)  n_errfirst++;
      if (prev_stall && m_valid && (m_data !== prev_data)) hold_viol++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // m_ready toggler for the back-pressure test
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) m_ready = ~m_ready;
    end
  end

  task automatic clear_mon();
    nw = 0;
    n_orphan = 0;
    n_errfirst = 0;
    hold_viol = 0;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic f, input logic l, input logic [15:0] d);
    logic got;
    int   n;
    s_first = f; s_last = l; s_data = d; s_valid = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk);
      got = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) chk("send_timeout", 64'(n), 64'd0);
    s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_test1(input string pfx);
    send(1'b1, 1'b0, 16'h0001);
    send(1'b0, 1'b0, 16'h0002);
    send(1'b0, 1'b0, 16'h0003);
    send(1'b0, 1'b0, 16'h0004);
    send(1'b0, 1'b1, 16'h0005);
    idle(12);
    chk({pfx, "_nwords"}, 64'(nw), 64'd2);
    chk({pfx, "_w0_data"}, 64'(w_data[0]), 64'h0300020001);
    chk({pfx, "_w0_flags"}, {62'd0, w_first[0], w_last[0]}, 64'b10);
    chk({pfx, "_w1_data"}, 64'(w_data[1]), 64'h0005000400);
    chk({pfx, "_w1_flags"}, {62'd0, w_first[1], w_last[1]}, 64'b01);
  endtask

  initial begin
    reset = 1'b1; cke = 1'b1; m_ready = 1'b1;
    s_first = 1'b0; s_last = 1'b0; s_valid = 1'b0; s_data = '0;
    idle(3);
    #2;
    reset = 1'b0;
    idle(2);

    // reset state
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data",  64'(m_data), 64'd0);
    chk("rst_m_flags", {62'd0, m_first, m_last}, 64'd0);
    chk("rst_err",     {62'd0, err_first, err_orphan}, 64'd0);

    // test 1: five beats, free-running output
    clear_mon();
    run_test1("t1");

    // test 2: residual word with zero padding
    clear_mon();
    send(1'b1, 1'b0, 16'hAAAA);
    send(1'b0, 1'b0, 16'hBBBB);
    send(1'b0, 1'b1, 16'hCCCC);
    idle(10);
    chk("t2_nwords", 64'(nw), 64'd2);
    chk("t2_w0_data", 64'(w_data[0]), 64'hCCBBBBAAAA);
    chk("t2_w0_flags", {62'd0, w_first[0], w_last[0]}, 64'b10);
    chk("t2_w1_data", 64'(w_data[1]), 64'h00000000CC);
    chk("t2_w1_flags", {62'd0, w_first[1], w_last[1]}, 64'b01);

    // test 3: test 1 under toggling back-pressure
    clear_mon();
    toggle_en = 1'b1;
    run_test1("t3");
    toggle_en = 1'b0;
    m_ready = 1'b1;
    chk("t3_stall_stable", 64'(hold_viol), 64'd0);
    idle(2);

    // test 4: orphan beat
    clear_mon();
    send(1'b0, 1'b0, 16'h1234);
    idle(6);
    chk("t4_orphan", 64'(n_orphan), 64'd1);
    chk("t4_nwords", 64'(nw), 64'd0);

    // test 5: restart inside an open packet
    clear_mon();
    send(1'b1, 1'b0, 16'h5555);
    send(1'b0, 1'b0, 16'h6666);
    send(1'b1, 1'b1, 16'h1111);
    idle(8);
    chk("t5_err_first", 64'(n_errfirst), 64'd1);
    chk("t5_orphan", 64'(n_orphan), 64'd0);
    chk("t5_nwords", 64'(nw), 64'd1);
    chk("t5_w0_data", 64'(w_data[0]), 64'h0000001111);
    chk("t5_w0_flags", {62'd0, w_first[0], w_last[0]}, 64'b11);

    // test 6: async reset while a word is pending
    clear_mon();
    m_ready = 1'b0;
    send(1'b1, 1'b0, 16'h0001);
    send(1'b0, 1'b0, 16'h0002);
    send(1'b0, 1'b0, 16'h0003);
    idle(3);
    chk("t6_pending_valid", 64'(m_valid), 64'd1);
    cke = 1'b0;
    #1;
    chk("t6_cke_low_ready", 64'(s_ready), 64'd0);
    cke = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(m_valid), 64'd0);
    chk("t6_rst_ready", 64'(s_ready), 64'd1);
    idle(2);
    #2;
    reset = 1'b0;
    m_ready = 1'b1;
    idle(2);
    clear_mon();
    run_test1("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
